// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared floating-point constants, flag indices, operand classes.
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // {0, all-ones exponent, 1, zeros}; callers slice to their word width.
  function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
    logic [127:0] ones;
    ones = (128'd1 << (exp_w + 1)) - 128'd1;
    return ones << (man_w - 1);
  endfunction

  // Subnormals are flushed, so any zero exponent classifies as ZERO.
  function automatic fp_class_e fp_classify(input logic exp_zero,
                                            input logic exp_ones,
                                            input logic frac_nz);
    if (exp_zero) return ZERO;
    if (exp_ones) return frac_nz ? NAN : INF;
    return NORM;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
// ============================================================================
// Module   : fp_round_rne
// Brief    : Combinational normalise-by-one plus round-to-nearest-even.
// Revision : 1.0 - initial release
// ============================================================================
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic [2*MAN_W+1:0]      prod,
  input  logic signed [EXP_W+1:0] exp_in,
  output logic [MAN_W-1:0]        frac,
  output logic signed [EXP_W+1:0] exp_out,
  output logic                    inexact
);

  localparam logic signed [EXP_W+1:0] C_ONE = 1;

  logic [2*MAN_W+1:0]      w_norm;
  logic [MAN_W:0]          w_mant;
  logic [MAN_W+1:0]        w_mant_r;
  logic signed [EXP_W+1:0] w_exp_n;
  logic                    w_guard;
  logic                    w_sticky;
  logic                    w_round_up;

  always_comb begin
    // Left-align so the hidden bit always sits at the top of the word.
    w_norm     = prod[2*MAN_W+1] ? prod : {prod[2*MAN_W:0], 1'b0};
    w_exp_n    = prod[2*MAN_W+1] ? exp_in + C_ONE : exp_in;
    w_mant     = w_norm[2*MAN_W+1:MAN_W+1];
    w_guard    = w_norm[MAN_W];
    w_sticky   = |w_norm[MAN_W-1:0];
    w_round_up = w_guard & (w_sticky | w_mant[0]);
    w_mant_r   = {1'b0, w_mant} + {{(MAN_W+1){1'b0}}, w_round_up};
    if (w_mant_r[MAN_W+1]) begin
      frac    = w_mant_r[MAN_W:1];
      exp_out = w_exp_n + C_ONE;
    end else begin
      frac    = w_mant_r[MAN_W-1:0];
      exp_out = w_exp_n;
    end
    inexact = w_guard | w_sticky;
  end

endmodule
`default_nettype wire

// File: rtl/fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_pipe
// Brief    : 3-stage valid/ready FP multiplier with RNE and exception flags.
//            Optional sideband tag enabled by FP_MULT_TAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
`ifdef FP_MULT_TAG_EN
  , parameter int TAG_W = 4
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   prod,
  output logic [3:0]             flags
`ifdef FP_MULT_TAG_EN
  , input  logic [TAG_W-1:0]     in_tag,
  output logic [TAG_W-1:0]       out_tag
`endif
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;

  localparam logic signed [EW-1:0] C_BIAS     = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] C_EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] C_EXP_ZERO = '0;
  localparam logic [W-1:0]         C_QNAN     = W'(fp_qnan(EXP_W, MAN_W));

  logic w_adv;
  assign w_adv    = !out_valid | out_ready;
  assign in_ready = w_adv;

  // ---------------- S1: unpack / classify / multiply ----------------
  logic [EXP_W-1:0]  w_ea, w_eb;
  logic [MAN_W-1:0]  w_fa, w_fb;
  fp_class_e         w_cls_a, w_cls_b;
  logic              w_s1_nan, w_s1_inf, w_s1_zero;
  logic [PW-1:0]     w_s1_prod;
  logic signed [EW-1:0] w_s1_exp;

  always_comb begin
    w_ea      = a[W-2:MAN_W];
    w_eb      = b[W-2:MAN_W];
    w_fa      = a[MAN_W-1:0];
    w_fb      = b[MAN_W-1:0];
    w_cls_a   = fp_classify(w_ea == '0, &w_ea, |w_fa);
    w_cls_b   = fp_classify(w_eb == '0, &w_eb, |w_fb);
    w_s1_nan  = (w_cls_a == NAN) | (w_cls_b == NAN) |
                ((w_cls_a == INF) & (w_cls_b == ZERO)) |
                ((w_cls_a == ZERO) & (w_cls_b == INF));
    w_s1_inf  = (w_cls_a == INF) | (w_cls_b == INF);
    w_s1_zero = (w_cls_a == ZERO) | (w_cls_b == ZERO);
    w_s1_prod = {{(MAN_W+1){1'b0}}, |w_ea, w_fa} *
                {{(MAN_W+1){1'b0}}, |w_eb, w_fb};
    w_s1_exp  = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - C_BIAS;
  end

  logic                 r_v1, r_sign1, r_nan1, r_inf1, r_zero1;
  logic [PW-1:0]        r_prod1;
  logic signed [EW-1:0] r_exp1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_sign1 <= 1'b0;
      r_nan1  <= 1'b0;
      r_inf1  <= 1'b0;
      r_zero1 <= 1'b0;
      r_prod1 <= '0;
      r_exp1  <= '0;
    end else if (w_adv) begin
      r_v1    <= in_valid;
      r_sign1 <= a[W-1] ^ b[W-1];
      r_nan1  <= w_s1_nan;
      r_inf1  <= w_s1_inf;
      r_zero1 <= w_s1_zero;
      r_prod1 <= w_s1_prod;
      r_exp1  <= w_s1_exp;
    end
  end

  // ---------------- S2: normalise / round ----------------
  logic [MAN_W-1:0]     w_rnd_frac;
  logic signed [EW-1:0] w_rnd_exp;
  logic                 w_rnd_inx;

  fp_round_rne #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .prod    (r_prod1),
    .exp_in  (r_exp1),
    .frac    (w_rnd_frac),
    .exp_out (w_rnd_exp),
    .inexact (w_rnd_inx)
  );

  logic                 r_v2, r_sign2, r_nan2, r_inf2, r_zero2, r_inx2;
  logic [MAN_W-1:0]     r_frac2;
  logic signed [EW-1:0] r_exp2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2    <= 1'b0;
      r_sign2 <= 1'b0;
      r_nan2  <= 1'b0;
      r_inf2  <= 1'b0;
      r_zero2 <= 1'b0;
      r_inx2  <= 1'b0;
      r_frac2 <= '0;
      r_exp2  <= '0;
    end else if (w_adv) begin
      r_v2    <= r_v1;
      r_sign2 <= r_sign1;
      r_nan2  <= r_nan1;
      r_inf2  <= r_inf1;
      r_zero2 <= r_zero1;
      r_inx2  <= w_rnd_inx;
      r_frac2 <= w_rnd_frac;
      r_exp2  <= w_rnd_exp;
    end
  end

  // ---------------- S3: special-case priority / pack ----------------
  logic [W-1:0] w_pack;
  logic [3:0]   w_flags;

  always_comb begin
    w_pack  = '0;
    w_flags = '0;
    if (r_nan2) begin
      w_pack           = C_QNAN;
      w_flags[FLG_INV] = 1'b1;
    end else if (r_inf2) begin
      w_pack = {r_sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (r_zero2) begin
      w_pack = {r_sign2, {(W-1){1'b0}}};
    end else if (r_exp2 >= C_EXP_MAX) begin
      w_pack           = {r_sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flags[FLG_OVF] = 1'b1;
      w_flags[FLG_INX] = 1'b1;
    end else if (r_exp2 <= C_EXP_ZERO) begin
      w_pack           = {r_sign2, {(W-1){1'b0}}};
      w_flags[FLG_UNF] = 1'b1;
      w_flags[FLG_INX] = 1'b1;
    end else begin
      w_pack           = {r_sign2, r_exp2[EXP_W-1:0], r_frac2};
      w_flags[FLG_INX] = r_inx2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      prod      <= '0;
      flags     <= '0;
    end else if (w_adv) begin
      out_valid <= r_v2;
      prod      <= w_pack;
      flags     <= w_flags;
    end
  end

`ifdef FP_MULT_TAG_EN
  logic [TAG_W-1:0] r_tag1, r_tag2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag1  <= '0;
      r_tag2  <= '0;
      out_tag <= '0;
    end else if (w_adv) begin
      r_tag1  <= in_tag;
      r_tag2  <= r_tag1;
      out_tag <= r_tag2;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mult_pipe
// Brief    : Directed self-checking bench for fp_mult_pipe (single precision).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] prod;
  logic [3:0]  flags;
`ifdef FP_MULT_TAG_EN
  logic [3:0]  in_tag = '0;
  logic [3:0]  out_tag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_mult_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .flags     (flags)
`ifdef FP_MULT_TAG_EN
    , .in_tag  (in_tag),
    .out_tag   (out_tag)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One operation with out_ready high: checks accept, latency, result, flags.
  task automatic send_check(input string tag, input logic [31:0] va, input logic [31:0] vb,
                            input logic [31:0] ep, input logic [3:0] ef);
    int lat;
    @(negedge clk);
    a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check($sformatf("%s_rdy", tag), 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s_lat", tag), 64'(lat), 64'd3);
    check($sformatf("%s_prod", tag), 64'(prod), 64'(ep));
    check($sformatf("%s_flags", tag), 64'(flags), 64'(ef));
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bp_a [5] = '{32'h40000000, 32'h40000000, 32'h40400000, 32'h3F800000, 32'hBF800000};
  logic [31:0] bp_b [5] = '{32'h40400000, 32'h40000000, 32'h40400000, 32'h40A00000, 32'h40000000};
  logic [31:0] bp_p [5] = '{32'h40C00000, 32'h40800000, 32'h41100000, 32'h40A00000, 32'hC0000000};

  initial begin
    int sent, got, wait_cnt, stale;

    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_prod",  64'(prod),      64'd0);
    check("rst_flags", 64'(flags),     64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    send_check("mul_2x3",   32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
    send_check("rne_up",    32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'b0001);
    send_check("rne_down",  32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    send_check("inf_x_0",   32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    send_check("ninf_x_2",  32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    send_check("nan_x_1",   32'h7FC01234, 32'h3F800000, 32'h7FC00000, 4'b1000);
    send_check("overflow",  32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
    send_check("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
    send_check("neg_sign",  32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000);
    send_check("neg_zero",  32'h80000000, 32'h40000000, 32'h80000000, 4'b0000);

    // Back-pressure: fill with out_ready low, then drain.
    sent = 0;
    got  = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      in_valid = (sent < 5);
      a = bp_a[(sent < 5) ? sent : 4];
      b = bp_b[(sent < 5) ? sent : 4];
      #1;
      if (in_valid && in_ready) sent++;
    end
    check("bp_accepts",  64'(sent),      64'd3);
    check("bp_in_ready", 64'(in_ready),  64'd0);
    check("bp_valid",    64'(out_valid), 64'd1);
    check("bp_hold0",    64'(prod),      64'(bp_p[0]));
    repeat (2) @(negedge clk);
    #1;
    check("bp_hold1",    64'(prod),      64'(bp_p[0]));

    for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (sent < 5);
      a = bp_a[(sent < 5) ? sent : 4];
      b = bp_b[(sent < 5) ? sent : 4];
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid) begin
        check($sformatf("bp_out%0d", got), 64'(prod), 64'(bp_p[got]));
        got++;
      end
    end
    in_valid = 1'b0;
    check("bp_got",  64'(got),  64'd5);
    check("bp_sent", 64'(sent), 64'd5);
    repeat (3) @(negedge clk);
    #1;
    check("bp_no_dup", 64'(out_valid), 64'd0);

    // Reset with operations in flight.
    out_ready = 1'b0;
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; in_valid = 1'b1;
    @(negedge clk);
    a = 32'h40000000; b = 32'h40000000;
    @(negedge clk);
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("rst2_filled", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst2_valid", 64'(out_valid), 64'd0);
    check("rst2_prod",  64'(prod),      64'd0);
    check("rst2_flags", 64'(flags),     64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_check("post_rst", 32'h3F800000, 32'h40A00000, 32'h40A00000, 4'b0000);
    stale = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      #1;
      if (out_valid) stale++;
    end
    check("post_rst_stale", 64'(stale), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
